// File: rtl/memory_stage_lsu.sv
// ME pipeline stage with a load/store unit: req/gnt/rvalid data-memory access, lane steering,
// load alignment/extension, branch resolution and WB registers. Optional: MEM_MISALIGN_TRAP_EN.
module memory_stage_lsu #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned MEM_AW = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_i,
    input  logic                   rf_we_i,
    input  logic                   mem_we_i,
    input  logic                   mem2rf_i,
    input  logic [1:0]             mem_size_i,
    input  logic                   mem_unsigned_i,
    input  logic                   branch_i,
    input  logic                   check_eq_i,
    input  logic [DATA_W-1:0]      mem_wdata_i,
    input  logic [ADDR_W-1:0]      rf_waddr_i,
    input  logic [DATA_W-1:0]      alu_result_i,
    input  logic [PC_W-1:0]        pc_branch_i,
    output logic                   valid_o,
    output logic                   rf_we_o,
    output logic                   mem2rf_o,
    output logic [ADDR_W-1:0]      rf_waddr_o,
    output logic [DATA_W-1:0]      mem_rdata_o,
    output logic [DATA_W-1:0]      alu_result_o,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic                   misalign_o,
`endif
    output logic                   pc_src_o,
    output logic [PC_W-1:0]        pc_branch_o,
    output logic                   stall_o,
    output logic                   dmem_req_o,
    output logic                   dmem_we_o,
    output logic [MEM_AW-1:0]      dmem_addr_o,
    output logic [DATA_W/8-1:0]    dmem_be_o,
    output logic [DATA_W-1:0]      dmem_wdata_o,
    input  logic                   dmem_gnt_i,
    input  logic                   dmem_rvalid_i,
    input  logic [DATA_W-1:0]      dmem_rdata_i
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(NB);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RDATA
    } state_t;

    state_t              r_state;
    logic [OFF_W-1:0]    r_off;
    logic [1:0]          r_size;
    logic                r_unsigned;

    logic                w_mem_op;
    logic                w_issue;
    logic                w_misalign;
    logic [1:0]          w_size;
    logic [3:0]          w_nbytes;
    logic [OFF_W-1:0]    w_off_raw;
    logic [OFF_W-1:0]    w_off;
    logic [NB-1:0]       w_be;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_shifted;
    logic [DATA_W-1:0]   w_load;
    logic                w_req;
    logic                w_done;
    logic                w_stall;

    assign w_mem_op  = valid_i & (mem_we_i | mem2rf_i);
    // Doubleword only exists on a 64-bit datapath; clamp it to word otherwise.
    assign w_size    = (DATA_W == 32 && mem_size_i == 2'd3) ? 2'd2 : mem_size_i;
    assign w_nbytes  = 4'(1) << w_size;
    assign w_off_raw = alu_result_i[OFF_W-1:0];
    assign w_misalign = |(w_off_raw & OFF_W'(w_nbytes - 4'd1));

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_off   = w_off_raw;
    assign w_issue = w_mem_op & ~w_misalign;
`else
    assign w_off   = w_misalign ? '0 : w_off_raw;
    assign w_issue = w_mem_op;
`endif

    assign w_be = NB'((16'(1) << w_nbytes) - 16'd1) << w_off;

    always_comb begin
        w_wdata = mem_wdata_i;
        case (w_size)
            2'd0:    w_wdata = {NB{mem_wdata_i[7:0]}};
            2'd1:    w_wdata = {(NB/2){mem_wdata_i[15:0]}};
            2'd2:    w_wdata = {(NB/4){mem_wdata_i[31:0]}};
            default: w_wdata = mem_wdata_i;
        endcase
    end

    // Load alignment uses the offset/size/sign captured when the request was granted.
    assign w_shifted = dmem_rdata_i >> {r_off, 3'b000};

    always_comb begin
        w_load = w_shifted;
        case (r_size)
            2'd0: w_load = r_unsigned ? DATA_W'(w_shifted[7:0])
                                      : DATA_W'($signed(w_shifted[7:0]));
            2'd1: w_load = r_unsigned ? DATA_W'(w_shifted[15:0])
                                      : DATA_W'($signed(w_shifted[15:0]));
            2'd2: w_load = r_unsigned ? DATA_W'(w_shifted[31:0])
                                      : DATA_W'($signed(w_shifted[31:0]));
            default: w_load = w_shifted;
        endcase
    end

    // Handshake decode: a store completes on grant, a load on rvalid.
    always_comb begin
        w_req   = 1'b0;
        w_done  = 1'b0;
        w_stall = 1'b0;
        case (r_state)
            S_IDLE, S_REQ: begin
                w_req   = w_issue;
                w_done  = w_issue & dmem_gnt_i & mem_we_i;
                w_stall = w_issue & ~w_done;
            end
            S_RDATA: begin
                w_done  = dmem_rvalid_i;
                w_stall = ~dmem_rvalid_i;
            end
            default: ;
        endcase
        if (reset) begin
            w_req   = 1'b0;
            w_done  = 1'b0;
            w_stall = 1'b0;
        end
    end

    assign stall_o      = w_stall;
    assign dmem_req_o   = w_req;
    assign dmem_we_o    = w_req & mem_we_i;
    assign dmem_addr_o  = MEM_AW'(alu_result_i) & ~MEM_AW'(NB - 1);
    assign dmem_be_o    = w_be;
    assign dmem_wdata_o = w_wdata;
    assign pc_src_o     = valid_i & branch_i & (check_eq_i ^ (|alu_result_i));
    assign pc_branch_o  = pc_branch_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_off      <= '0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_REQ: begin
                    if (!w_issue) begin
                        r_state <= S_IDLE;
                    end else if (!dmem_gnt_i) begin
                        r_state <= S_REQ;
                    end else if (mem_we_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state    <= S_RDATA;
                        r_off      <= w_off;
                        r_size     <= w_size;
                        r_unsigned <= mem_unsigned_i;
                    end
                end
                S_RDATA: begin
                    if (dmem_rvalid_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // WB slot: bubble while stalled, otherwise take this instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_o      <= 1'b0;
            rf_we_o      <= 1'b0;
            mem2rf_o     <= 1'b0;
            rf_waddr_o   <= '0;
            alu_result_o <= '0;
            mem_rdata_o  <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_o   <= 1'b0;
`endif
        end else begin
            rf_waddr_o   <= rf_waddr_i;
            alu_result_o <= alu_result_i;
            if (w_stall) begin
                valid_o  <= 1'b0;
                rf_we_o  <= 1'b0;
                mem2rf_o <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
                misalign_o <= 1'b0;
`endif
            end else begin
                valid_o  <= valid_i;
                mem2rf_o <= mem2rf_i & valid_i;
`ifdef MEM_MISALIGN_TRAP_EN
                misalign_o <= w_mem_op & w_misalign;
                rf_we_o    <= rf_we_i & valid_i & ~(w_mem_op & w_misalign);
`else
                rf_we_o    <= rf_we_i & valid_i;
`endif
            end
            if (r_state == S_RDATA && dmem_rvalid_i && !reset) begin
                mem_rdata_o <= w_load;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage_lsu.sv
// Directed self-checking bench for memory_stage_lsu (32-bit datapath).
// Honours MEM_MISALIGN_TRAP_EN when defined for the misaligned-load step.
module tb_memory_stage_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i, rf_we_i, mem_we_i, mem2rf_i, mem_unsigned_i, branch_i, check_eq_i;
    logic [1:0]  mem_size_i;
    logic [31:0] mem_wdata_i, alu_result_i, pc_branch_i;
    logic [4:0]  rf_waddr_i;
    logic        valid_o, rf_we_o, mem2rf_o, pc_src_o, stall_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] mem_rdata_o, alu_result_o, pc_branch_o;
    logic        dmem_req_o, dmem_we_o, dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
    logic [3:0]  dmem_be_o;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    memory_stage_lsu dut (
        .clk(clk), .reset(reset),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_o(misalign_o),
`endif
        .valid_i(valid_i), .rf_we_i(rf_we_i), .mem_we_i(mem_we_i), .mem2rf_i(mem2rf_i),
        .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i), .branch_i(branch_i),
        .check_eq_i(check_eq_i), .mem_wdata_i(mem_wdata_i), .rf_waddr_i(rf_waddr_i),
        .alu_result_i(alu_result_i), .pc_branch_i(pc_branch_i),
        .valid_o(valid_o), .rf_we_o(rf_we_o), .mem2rf_o(mem2rf_o), .rf_waddr_o(rf_waddr_o),
        .mem_rdata_o(mem_rdata_o), .alu_result_o(alu_result_o), .pc_src_o(pc_src_o),
        .pc_branch_o(pc_branch_o), .stall_o(stall_o), .dmem_req_o(dmem_req_o),
        .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i(dmem_rdata_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        valid_i = 0; rf_we_i = 0; mem_we_i = 0; mem2rf_i = 0; mem_size_i = 2'd0;
        mem_unsigned_i = 0; branch_i = 0; check_eq_i = 0; mem_wdata_i = '0;
        rf_waddr_i = '0; alu_result_i = '0; pc_branch_i = '0;
        dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = '0;
    endtask

    task automatic load(input logic [31:0] addr, input logic [1:0] size, input logic uns);
        clr();
        valid_i = 1; rf_we_i = 1; mem2rf_i = 1; rf_waddr_i = 5'd5;
        alu_result_i = addr; mem_size_i = size; mem_unsigned_i = uns;
    endtask

    initial begin
        reset = 1;
        clr();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_o", 32'(valid_o), 32'd0);
        chk("rst_rf_we_o", 32'(rf_we_o), 32'd0);
        chk("rst_mem_rdata_o", mem_rdata_o, 32'd0);
        chk("rst_req", 32'(dmem_req_o), 32'd0);
        @(negedge clk) reset = 0;

        // SW 0x10, granted immediately: no stall
        @(negedge clk);
        clr();
        valid_i = 1; mem_we_i = 1; mem_size_i = 2'd2; alu_result_i = 32'h10;
        mem_wdata_i = 32'hDEADBEEF; dmem_gnt_i = 1;
        #1;
        chk("sw_req", 32'(dmem_req_o), 32'd1);
        chk("sw_we", 32'(dmem_we_o), 32'd1);
        chk("sw_addr", dmem_addr_o, 32'h10);
        chk("sw_be", 32'(dmem_be_o), 32'hF);
        chk("sw_wdata", dmem_wdata_o, 32'hDEADBEEF);
        chk("sw_stall", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        chk("sw_wb_valid", 32'(valid_o), 32'd1);

        // LB 0x13: grant now, rvalid next cycle
        @(negedge clk);
        load(32'h13, 2'd0, 1'b0); dmem_gnt_i = 1;
        #1;
        chk("lb_req", 32'(dmem_req_o), 32'd1);
        chk("lb_we", 32'(dmem_we_o), 32'd0);
        chk("lb_addr", dmem_addr_o, 32'h10);
        chk("lb_be", 32'(dmem_be_o), 32'h8);
        chk("lb_stall0", 32'(stall_o), 32'd1);
        @(posedge clk); #1;
        chk("lb_bubble", 32'(valid_o), 32'd0);
        @(negedge clk);
        dmem_gnt_i = 0; dmem_rvalid_i = 1; dmem_rdata_i = 32'h80FFFF00;
        #1;
        chk("lb_req_rdata", 32'(dmem_req_o), 32'd0);
        chk("lb_stall1", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        chk("lb_data", mem_rdata_o, 32'hFFFFFF80);
        chk("lb_wb_valid", 32'(valid_o), 32'd1);
        chk("lb_wb_rfwe", 32'(rf_we_o), 32'd1);
        chk("lb_wb_mem2rf", 32'(mem2rf_o), 32'd1);
        chk("lb_wb_waddr", 32'(rf_waddr_o), 32'd5);

        // LBU 0x13
        @(negedge clk);
        load(32'h13, 2'd0, 1'b1); dmem_gnt_i = 1;
        @(posedge clk);
        @(negedge clk);
        dmem_gnt_i = 0; dmem_rvalid_i = 1; dmem_rdata_i = 32'h80FFFF00;
        @(posedge clk); #1;
        chk("lbu_data", mem_rdata_o, 32'h00000080);

        // SH 0x12, grant delayed 3 cycles
        @(negedge clk);
        clr();
        valid_i = 1; mem_we_i = 1; mem_size_i = 2'd1; alu_result_i = 32'h12;
        mem_wdata_i = 32'h00001234;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("sh_req_wait", 32'(dmem_req_o), 32'd1);
            chk("sh_be", 32'(dmem_be_o), 32'hC);
            chk("sh_wdata", dmem_wdata_o, 32'h12341234);
            chk("sh_stall", 32'(stall_o), 32'd1);
            @(posedge clk); #1;
            chk("sh_bubble", 32'(valid_o), 32'd0);
            @(negedge clk);
        end
        dmem_gnt_i = 1;
        #1;
        chk("sh_gnt_stall", 32'(stall_o), 32'd0);
        chk("sh_gnt_addr", dmem_addr_o, 32'h10);
        @(posedge clk); #1;
        chk("sh_wb_valid", 32'(valid_o), 32'd1);

        // Branch resolution and a plain ALU op
        @(negedge clk);
        clr();
        valid_i = 1; branch_i = 1; check_eq_i = 0; alu_result_i = 32'd5; pc_branch_i = 32'h400;
        #1;
        chk("bne_ne", 32'(pc_src_o), 32'd1);
        chk("pc_branch", pc_branch_o, 32'h400);
        check_eq_i = 1; alu_result_i = 32'd0;
        #1;
        chk("beq_eq", 32'(pc_src_o), 32'd1);
        alu_result_i = 32'd5;
        #1;
        chk("beq_ne", 32'(pc_src_o), 32'd0);
        @(negedge clk);
        clr();
        valid_i = 1; rf_we_i = 1; rf_waddr_i = 5'd9; alu_result_i = 32'h55;
        #1;
        chk("alu_req", 32'(dmem_req_o), 32'd0);
        @(posedge clk); #1;
        chk("alu_result_o", alu_result_o, 32'h55);
        chk("alu_rf_we_o", 32'(rf_we_o), 32'd1);
        chk("alu_waddr", 32'(rf_waddr_o), 32'd9);

        // Reset while waiting for read data; late rvalid discarded
        @(negedge clk);
        load(32'h20, 2'd2, 1'b0); dmem_gnt_i = 1;
        @(posedge clk);
        @(negedge clk);
        dmem_gnt_i = 0;
        #1;
        chk("rst_mid_stall", 32'(stall_o), 32'd1);
        reset = 1;
        #1;
        chk("rst_mid_req", 32'(dmem_req_o), 32'd0);
        chk("rst_mid_stall_drop", 32'(stall_o), 32'd0);
        chk("rst_mid_rdata", mem_rdata_o, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 0; clr();
        dmem_rvalid_i = 1; dmem_rdata_i = 32'h12345678;
        #1;
        chk("late_rvalid_stall", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        chk("late_rvalid_data", mem_rdata_o, 32'd0);
        chk("late_rvalid_valid", 32'(valid_o), 32'd0);

        // Misaligned LW 0x02
        @(negedge clk);
        load(32'h02, 2'd2, 1'b0); rf_waddr_i = 5'd7; dmem_gnt_i = 1;
        #1;
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis_req", 32'(dmem_req_o), 32'd0);
        chk("mis_stall", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        chk("mis_flag", 32'(misalign_o), 32'd1);
        chk("mis_rf_we", 32'(rf_we_o), 32'd0);
        chk("mis_valid", 32'(valid_o), 32'd1);
        @(negedge clk);
        clr();
        @(posedge clk); #1;
        chk("mis_flag_clear", 32'(misalign_o), 32'd0);
`else
        chk("mis_req", 32'(dmem_req_o), 32'd1);
        chk("mis_addr", dmem_addr_o, 32'h0);
        chk("mis_be", 32'(dmem_be_o), 32'hF);
        chk("mis_stall", 32'(stall_o), 32'd1);
        @(posedge clk);
        @(negedge clk);
        dmem_gnt_i = 0; dmem_rvalid_i = 1; dmem_rdata_i = 32'hCAFEF00D;
        @(posedge clk); #1;
        chk("mis_data", mem_rdata_o, 32'hCAFEF00D);
        chk("mis_valid", 32'(valid_o), 32'd1);
        chk("mis_waddr", 32'(rf_waddr_o), 32'd7);
`endif

        @(negedge clk);
        clr();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
